// File: rtl/spart_core.sv
// -----------------------------------------------------------------------------
// spart_core
// Bus-side responder and 8N1 serial engine for the SPART. Decodes the 4-address
// iocs/iorw/ioaddr/databus interface, holds a programmable 16-bit baud divisor
// and runs a transmitter and receiver at 16x oversampling.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   iocs     in   chip select
//   iorw     in   1 = read (SPART drives databus), 0 = write
//   ioaddr   in   register address: 00 TX/RX data, 01 status, 10 DB_LO, 11 DB_HI
//   databus  io   shared 8-bit data bus, driven only while iocs && iorw
//   rda      out  receive buffer holds an unread byte
//   tbr      out  transmitter idle, a TX write will be accepted
//   txd      out  serial output, idle high
//   rxd      in   serial input, asynchronous, idle high
//
// Build option
//   SPART_LOOPBACK_EN  when defined the receiver listens to the internal txd
//                      instead of the rxd pin.
// -----------------------------------------------------------------------------
module spart_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TCNT_W = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [DIV_W-1:0]  DIV_RST   = 16'h0516;
    localparam logic [TCNT_W-1:0] TCNT_LAST = 4'd15;
    localparam logic [TCNT_W-1:0] TCNT_MID  = 4'd7;
    localparam logic [BIT_W-1:0]  BIT_LAST  = 3'd7;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBLO = 2'b10;
    localparam logic [1:0] ADDR_DBHI = 2'b11;

    // Shared state encoding for both serial FSMs
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------------------------------------------------------- registers
    logic [DATA_W-1:0] div_lo_q, div_lo_d;
    logic [DATA_W-1:0] div_hi_q, div_hi_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic              reload_q, reload_d;

    logic [1:0]        tx_state_q, tx_state_d;
    logic [TCNT_W-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              txd_q, txd_d;

    logic              rx_sync1_q, rx_sync1_d;
    logic              rx_sync2_q, rx_sync2_d;
    logic [1:0]        rx_state_q, rx_state_d;
    logic [TCNT_W-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_buf_q, rx_buf_d;
    logic              rda_q, rda_d;
    logic              ovr_q, ovr_d;

    // ---------------------------------------------------------------- bus decode
    logic              bus_wr_c;
    logic              bus_rd_c;
    logic              rd_data_c;
    logic              rd_stat_c;
    logic [DATA_W-1:0] rd_mux_c;

    assign bus_wr_c  = iocs && !iorw;
    assign bus_rd_c  = iocs && iorw;
    assign rd_data_c = bus_rd_c && (ioaddr == ADDR_DATA);
    assign rd_stat_c = bus_rd_c && (ioaddr == ADDR_STAT);

    // Read data is a pure function of the address while selected
    always_comb begin
        rd_mux_c = '0;
        case (ioaddr)
            ADDR_DATA: rd_mux_c = rx_buf_q;
            ADDR_STAT: rd_mux_c = {5'b0, ovr_q, tbr, rda_q};
            ADDR_DBLO: rd_mux_c = div_lo_q;
            ADDR_DBHI: rd_mux_c = div_hi_q;
            default:   rd_mux_c = '0;
        endcase
    end

    assign databus = bus_rd_c ? rd_mux_c : 8'bzzzz_zzzz;

    // ---------------------------------------------------------------- baud generator
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] div_eff_c;
    logic             tick_c;

    assign div_c     = {div_hi_q, div_lo_q};
    assign div_eff_c = (div_c == '0) ? DIV_W'(1) : div_c;
    // A pending reload suppresses the tick so the new period starts cleanly
    assign tick_c    = !reload_q && (baud_cnt_q <= DIV_W'(1));

    always_comb begin
        div_lo_d   = div_lo_q;
        div_hi_d   = div_hi_q;
        reload_d   = 1'b0;
        baud_cnt_d = baud_cnt_q - DIV_W'(1);
        if (bus_wr_c && (ioaddr == ADDR_DBLO)) begin
            div_lo_d = databus;
            reload_d = 1'b1;
        end
        if (bus_wr_c && (ioaddr == ADDR_DBHI)) begin
            div_hi_d = databus;
            reload_d = 1'b1;
        end
        if (reload_q || tick_c) begin
            baud_cnt_d = div_eff_c;
        end
    end

    // ---------------------------------------------------------------- transmitter
    logic tx_bit_end_c;

    assign tx_bit_end_c = tick_c && (tx_tcnt_q == TCNT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        txd_d      = 1'b1;

        // 16 ticks per bit; the 4-bit counter wraps naturally at the bit end
        if ((tx_state_q != S_IDLE) && tick_c) begin
            tx_tcnt_d = tx_tcnt_q + TCNT_W'(1);
        end

        case (tx_state_q)
            S_IDLE: begin
                if (bus_wr_c && (ioaddr == ADDR_DATA)) begin
                    tx_data_d  = databus;
                    tx_state_d = S_START;
                    tx_tcnt_d  = '0;
                    tx_bit_d   = '0;
                end
            end
            S_START: begin
                if (tx_bit_end_c) begin
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_bit_end_c) begin
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (tx_bit_end_c) begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so txd is registered
        case (tx_state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_data_d[tx_bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    assign tbr = (tx_state_q == S_IDLE);
    assign txd = txd_q;

    // ---------------------------------------------------------------- receiver
    logic rx_in_c;
    logic rx_line_c;
    logic rx_deliver_c;

`ifdef SPART_LOOPBACK_EN
    assign rx_in_c = txd_q;
`else
    assign rx_in_c = rxd;
`endif

    assign rx_line_c = rx_sync2_q;

    always_comb begin
        rx_sync1_d   = rx_in_c;
        rx_sync2_d   = rx_sync1_q;
        rx_state_d   = rx_state_q;
        rx_tcnt_d    = rx_tcnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_deliver_c = 1'b0;

        case (rx_state_q)
            S_IDLE: begin
                if (!rx_line_c) begin
                    rx_state_d = S_START;
                    rx_tcnt_d  = '0;
                end
            end
            S_START: begin
                // Re-check the line half a bit in to reject glitches
                if (tick_c) begin
                    if (rx_tcnt_q == TCNT_MID) begin
                        rx_tcnt_d = '0;
                        rx_bit_d  = '0;
                        rx_state_d = rx_line_c ? S_IDLE : S_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
                    if (rx_tcnt_q == TCNT_LAST) begin
                        rx_shift_d = {rx_line_c, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_d = S_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
                    if (rx_tcnt_q == TCNT_LAST) begin
                        rx_state_d   = S_IDLE;
                        rx_deliver_c = rx_line_c;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Receive buffer and flags; a completing byte beats a same-cycle read
    always_comb begin
        rx_buf_d = rx_buf_q;
        rda_d    = rda_q;
        ovr_d    = ovr_q;
        if (rd_data_c) begin
            rda_d = 1'b0;
        end
        if (rd_stat_c) begin
            ovr_d = 1'b0;
        end
        if (rx_deliver_c) begin
            rx_buf_d = rx_shift_q;
            rda_d    = 1'b1;
            if (rda_q && !rd_data_c) begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rda = rda_q;

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_lo_q   <= DIV_RST[7:0];
            div_hi_q   <= DIV_RST[15:8];
            baud_cnt_q <= DIV_RST;
            reload_q   <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            txd_q      <= 1'b1;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_buf_q   <= '0;
            rda_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            div_lo_q   <= div_lo_d;
            div_hi_q   <= div_hi_d;
            baud_cnt_q <= baud_cnt_d;
            reload_q   <= reload_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            txd_q      <= txd_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            ovr_q      <= ovr_d;
        end
    end

endmodule

// File: doc/spart_core.md
# spart_core

Bus-side responder and serial engine for the SPART (Special Purpose Asynchronous Receiver/Transmitter). It decodes the 4-address `iocs`/`iorw`/`ioaddr`/`databus` processor interface and holds a programmable 16-bit baud divisor. It implements an 8N1 transmitter and receiver at 16x oversampling and reports `rda` (receive data available) and `tbr` (transmit buffer ready) back to the bus master. It sits between the bus driver and the board RS-232 pins (`txd`/`rxd`).

## Interface
- No parameters.
- `clk` in 1: system clock (50 MHz nominal).
- `rst` in 1: synchronous, active-high reset on clock `clk`.
- `iocs` in 1: chip select; a bus access happens only when high.
- `iorw` in 1: 1 = read (SPART drives `databus`), 0 = write (master drives `databus`).
- `ioaddr` in 2: register address.
- `databus` inout 8: shared data bus. Driven by SPART only when `iocs && iorw`, otherwise Z.
- `rda` out 1: receive buffer holds an unread byte.
- `tbr` out 1: transmitter idle; a TX write is accepted.
- `txd` out 1: serial output, idle high.
- `rxd` in 1: serial input, asynchronous, idle high.

## Operation
- Register map:
  - Addr 00: write loads the TX byte; read returns the RX buffer.
  - Addr 01: read returns status `{5'b0, ovr, tbr, rda}`; write is ignored.
  - Addr 10: read/write divisor low byte (DB_LO).
  - Addr 11: read/write divisor high byte (DB_HI).
- Read data is combinational from `ioaddr` while `iocs && iorw`.
- Baud generator: 16-bit down counter loaded with `{DB_HI,DB_LO}`.
  - Emits a one-cycle `tick` and reloads on reaching 1. Tick period = divisor clocks.
  - Divisor 0 is treated as 1 (tick every cycle).
  - Any divisor write reloads the counter on the next cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - A write to addr 00 while `tbr=1` latches the byte and enters START. Writes while `tbr=0` are dropped.
  - Each bit lasts 16 ticks. Data is sent LSB first (bits 0..7), then one stop bit of 1, then IDLE.
  - `tbr` = (state == IDLE).
- RX FSM states: IDLE, START, DATA, STOP.
  - `rxd` passes through a 2-flop synchronizer.
  - A low level in IDLE enters START. At tick 8 of START, if the line is high again the start is false and the FSM returns to IDLE.
  - Each data bit is sampled at tick 16 after the previous sample (mid-bit), LSB first.
  - If the stop sample is 1, the byte goes to the RX buffer and `rda` is set. If the stop sample is 0 (framing error), the byte is discarded and `rda` is unchanged.
- `rda` clears on the clock edge where `iocs && iorw && ioaddr==00`.
- Overrun: a new byte arriving while `rda=1` overwrites the buffer and sets `ovr`. A read of addr 01 clears `ovr`.
- Simultaneous RX completion and RX-buffer read: the new byte wins, `rda` stays 1, `ovr` is not set.

## Timing
- Reset values:
  - `txd=1`, `tbr=1`, `rda=0`, `ovr=0`, RX buffer `8'h00`.
  - Divisor `16'h0516`, which gives 2400 baud at 50 MHz.
  - Both FSMs in IDLE; `databus` Z.
- Register writes take effect on the edge where `iocs && !iorw`.
- TX start: `tbr` falls and `txd` falls on the cycle after the accepting write edge.
- A TX frame lasts 160 ticks. `tbr` rises on the cycle after the final stop-bit tick.
- RX latency: `rda` rises at most 3 cycles after the mid-stop-bit tick (2 synchronizer + 1 register).
- Reset mid-frame aborts both FSMs immediately: `txd` returns high and any partial RX byte is lost.

## Configuration
- `SPART_LOOPBACK_EN`:
  - Defined: the RX synchronizer input is internal `txd`, and `rxd` is ignored. `txd` pin behaviour is unchanged.
  - Undefined: RX samples `rxd`.

## Test plan
- Reset, then read addr 10/11 -> `8'h16`/`8'h05`; status read -> `8'h02`; `txd=1`.
- Write divisor `16'h0004`, write `8'hA5` to addr 00 -> `txd` carries 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks. `tbr` low for 640 clocks.
- Drive frame `8'h3C` on `rxd` at divisor 4 -> `rda=1`; addr 00 read returns `8'h3C`; `rda=0` the following cycle.
- Two frames `8'h11` then `8'h22` with no read between -> buffer `8'h22`, status `8'h07`; status read clears `ovr` (next status `8'h03`).
- `rxd` low pulse of 4 ticks, then a frame with stop bit 0 -> no `rda` in either case; FSM back to IDLE.
- With `SPART_LOOPBACK_EN`, write `8'h5A` -> `rda=1` and RX buffer `8'h5A` after one frame; `rst` asserted mid-frame -> `txd=1`, `tbr=1`, `rda=0`.
